unidad_deteccion_riesgos: RTL and testbench
===========================================

UNIDAD_DETECCION_RIESGOS -- requirements
Module: unidad_deteccion_riesgos

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5: register-specifier width.
REQ-002 SHALL have parameter CNT_W, default 32: stall-counter width.
REQ-003 SHALL have port i_clk, input, 1: sole clock, rising edge; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port i_reset, input, 1: synchronous active-high reset.
REQ-005 SHALL have port i_rs_ID, input, REG_ADDR_W: rs field of the instruction in ID.
REQ-006 SHALL have port i_rt_ID, input, REG_ADDR_W: rt field of the instruction in ID.
REQ-007 SHALL have port i_rt_EX, input, REG_ADDR_W: destination rt of the instruction in EX.
REQ-008 SHALL have port i_mem_read_EX, input, 1: the EX instruction is a load.
REQ-009 SHALL have port o_stall, output, 1: load-use hazard, combinational.
REQ-010 SHALL have port o_pc_write_en, output, 1: PC write enable.
REQ-011 SHALL have port o_if_id_write_en, output, 1: IF/ID register write enable.
REQ-012 SHALL have port o_id_ex_bubble, output, 1: zero the ID/EX control signals.
REQ-013 SHALL have port o_stall_count, output, CNT_W: saturating count of stalled cycles.

Function
REQ-014 SHALL set o_stall = i_mem_read_EX AND ((i_rt_EX == i_rs_ID) OR (i_rt_EX == i_rt_ID)), purely combinational with zero cycles of latency.
REQ-015 SHALL include register 0 in the comparison, with no special case for it.
REQ-016 SHALL never assert o_stall while i_mem_read_EX = 0, regardless of whether the register fields match.
REQ-017 SHALL derive o_stall only from i_rs_ID, i_rt_ID, i_rt_EX and i_mem_read_EX; it is independent of i_clk, i_reset and the counter state.
REQ-018 SHALL drive o_pc_write_en = NOT o_stall, o_if_id_write_en = NOT o_stall and o_id_ex_bubble = o_stall, all combinational.
REQ-019 SHALL increment o_stall_count by 1 on each rising edge of i_clk where o_stall = 1 and i_reset = 0.
REQ-020 SHALL saturate o_stall_count at 2^CNT_W-1, with no wrap-around.
REQ-021 SHALL give i_reset priority when it is asserted in the same cycle as a stall, so that the counter clears.

Reset
REQ-022 SHALL clear o_stall_count to 0 on a rising i_clk edge with i_reset = 1.
REQ-023 SHALL leave o_stall, o_pc_write_en, o_if_id_write_en and o_id_ex_bubble unaffected by reset; these outputs have no reset value and follow their inputs at all times.
REQ-024 SHALL keep the comparison logic functional while reset is held, including mid-operation.

Structure
REQ-025 SHALL place REG_ADDR_W and the pipeline register-address type in the shared pipeline package.
REQ-026 SHALL use no sub-module; the block is a comparator pair plus one counter register.
REQ-027 SHALL contain no latches, with all combinational outputs fully assigned.

Verification
REQ-028 SHALL verify: all inputs 0 and mem_read=0 -> stall=0, pc_write_en=1.
REQ-029 SHALL verify: mem_read=1, rt_EX=2, rs_ID=1, rt_ID=3 -> stall=0.
REQ-030 SHALL verify: rt_EX=rs_ID=rt_ID=2 -> stall=0 with mem_read=0, then stall=1 after switching to mem_read=1.
REQ-031 SHALL verify: mem_read=1 with rt_EX=25, rs_ID=25, rt_ID=2 -> stall=1; with rt_EX=31, rs_ID=25, rt_ID=31 -> stall=1; with rt_EX=31, rs_ID=25, rt_ID=20 -> stall=0.
REQ-032 SHALL verify: mem_read=0 with rt_EX=25, rs_ID=25 -> stall=0; mem_read=1 with rt_EX=20, rt_ID=20 -> stall=1, if_id_write_en=0, id_ex_bubble=1.
REQ-033 SHALL verify: reset, then 3 clocked stall cycles -> count=3; reset asserted during a stall -> count=0; CNT_W=2 with 5 stall cycles -> count=3.

Source files
------------

// File: rtl/unidad_deteccion_riesgos_pkg.sv
// Shared pipeline definitions: register-specifier width and address type.
package unidad_deteccion_riesgos_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // True when the load in EX writes a register the ID instruction reads.
  function automatic logic load_use(input reg_addr_t rt_ex,
                                    input reg_addr_t rs_id,
                                    input reg_addr_t rt_id,
                                    input logic      mem_read_ex);
    return mem_read_ex && ((rt_ex == rs_id) || (rt_ex == rt_id));
  endfunction

endpackage

// File: rtl/unidad_deteccion_riesgos.sv
// Load-use hazard detector: stalls PC and IF/ID and bubbles ID/EX when
// the load in EX targets a source register of the instruction in ID.
// Also keeps a saturating count of stalled cycles.
module unidad_deteccion_riesgos #(
  parameter int REG_ADDR_W = unidad_deteccion_riesgos_pkg::REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [REG_ADDR_W-1:0] i_rs_ID,
  input  logic [REG_ADDR_W-1:0] i_rt_ID,
  input  logic [REG_ADDR_W-1:0] i_rt_EX,
  input  logic                  i_mem_read_EX,
  output logic                  o_stall,
  output logic                  o_pc_write_en,
  output logic                  o_if_id_write_en,
  output logic                  o_id_ex_bubble,
  output logic [CNT_W-1:0]      o_stall_count
);

  logic             stall;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  // Hazard compare and pipeline control; register 0 is compared like any other.
  always_comb begin
    stall            = i_mem_read_EX && ((i_rt_EX == i_rs_ID) || (i_rt_EX == i_rt_ID));
    o_stall          = stall;
    o_pc_write_en    = !stall;
    o_if_id_write_en = !stall;
    o_id_ex_bubble   = stall;
  end

  // Next count: increment on stall, hold at all-ones instead of wrapping.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != {CNT_W{1'b1}}))
      stall_count_d = stall_count_q + 1'b1;
  end

  // Counter register; reset wins over a coincident stall.
  always_ff @(posedge i_clk) begin
    if (i_reset) stall_count_q <= '0;
    else         stall_count_q <= stall_count_d;
  end

  assign o_stall_count = stall_count_q;

endmodule

// File: tb/tb_unidad_deteccion_riesgos.sv
// Bench for unidad_deteccion_riesgos: directed cases then random traffic,
// checked against a behavioural model. A second instance with a 2-bit
// counter exercises saturation.
module tb_unidad_deteccion_riesgos;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_id, rt_id, rt_ex;
  logic       mr;

  logic        stall, pcw, ifidw, bub;
  logic [31:0] cnt;
  logic        stall2, pcw2, ifidw2, bub2;
  logic [1:0]  cnt2;

  int checks   = 0;
  int failures = 0;

  longint m_cnt;   // reference count for the 32-bit instance
  int     m_cnt2;  // reference count for the 2-bit instance

  always #5 clk = ~clk;

  unidad_deteccion_riesgos dut (
    .i_clk(clk), .i_reset(rst), .i_rs_ID(rs_id), .i_rt_ID(rt_id),
    .i_rt_EX(rt_ex), .i_mem_read_EX(mr), .o_stall(stall),
    .o_pc_write_en(pcw), .o_if_id_write_en(ifidw), .o_id_ex_bubble(bub),
    .o_stall_count(cnt));

  unidad_deteccion_riesgos #(.CNT_W(2)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_rs_ID(rs_id), .i_rt_ID(rt_id),
    .i_rt_EX(rt_ex), .i_mem_read_EX(mr), .o_stall(stall2),
    .o_pc_write_en(pcw2), .o_if_id_write_en(ifidw2), .o_id_ex_bubble(bub2),
    .o_stall_count(cnt2));

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Hazard exists when a load's destination equals either ID source.
  function automatic bit ref_stall(input int a_rs, input int a_rt,
                                   input int a_ex, input bit a_mr);
    return a_mr && (a_ex == a_rs || a_ex == a_rt);
  endfunction

  // Drive one cycle of inputs, check combinational outputs, clock, check counts.
  task automatic step(input string tag, input int a_rs, input int a_rt,
                      input int a_ex, input bit a_mr, input bit a_rst);
    bit s;
    @(negedge clk);
    rs_id = 5'(a_rs); rt_id = 5'(a_rt); rt_ex = 5'(a_ex); mr = a_mr; rst = a_rst;
    #1;
    s = ref_stall(a_rs, a_rt, a_ex, a_mr);
    check({tag, ".stall"},  longint'(stall), longint'(s));
    check({tag, ".pcw"},    longint'(pcw),   longint'(!s));
    check({tag, ".ifidw"},  longint'(ifidw), longint'(!s));
    check({tag, ".bubble"}, longint'(bub),   longint'(s));
    check({tag, ".stall2"}, longint'(stall2), longint'(s));
    @(posedge clk);
    if (a_rst) begin
      m_cnt = 0; m_cnt2 = 0;
    end else if (s) begin
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    #1;
    check({tag, ".cnt"},  longint'(cnt),  m_cnt);
    check({tag, ".cnt2"}, longint'(cnt2), longint'(m_cnt2));
  endtask

  initial begin
    int r_rs, r_rt, r_ex;
    bit r_mr, r_rst;
    m_cnt = 0; m_cnt2 = 0;
    rs_id = '0; rt_id = '0; rt_ex = '0; mr = 1'b0; rst = 1'b1;

    step("reset",      0, 0, 0, 0, 1);
    step("all_zero",   0, 0, 0, 0, 0);
    step("no_match",   1, 3, 2, 1, 0);
    step("eq_no_load", 2, 2, 2, 0, 0);
    step("eq_load",    2, 2, 2, 1, 0);
    step("rs25",      25, 2, 25, 1, 0);
    step("rt31",      25, 31, 31, 1, 0);
    step("miss31",    25, 20, 31, 1, 0);
    step("rs25_nold", 25, 0, 25, 0, 0);
    step("rt20",       0, 20, 20, 1, 0);
    step("reg0",       0, 7, 0, 1, 0);

    // Three counted stalls from a clean reset.
    step("rst_a", 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("stall3", 4, 9, 4, 1, 0);
    check("count_eq_3", longint'(cnt), 3);

    // Reset coincident with a stall clears the counter; stall still visible.
    step("rst_in_stall", 4, 9, 4, 1, 1);
    check("count_cleared", longint'(cnt), 0);

    // Five stalls saturate the 2-bit counter at 3.
    for (int i = 0; i < 5; i++) step("sat5", 6, 6, 6, 1, 0);
    check("sat_cnt2", longint'(cnt2), 3);
    check("cnt_eq_5", longint'(cnt), 5);

    // Random traffic; narrow address range makes matches frequent.
    for (int i = 0; i < 300; i++) begin
      r_rs  = (i % 3 == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3));
      r_rt  = int'($urandom_range(0, 3));
      r_ex  = int'($urandom_range(0, 3));
      r_mr  = bit'($urandom_range(0, 1));
      r_rst = ($urandom_range(0, 19) == 0);
      step("rand", r_rs, r_rt, r_ex, r_mr, r_rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
